// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and width/reset defaults.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        REQ   = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam int          FETCH_ADDR_W   = 32;
    localparam int          FETCH_DATA_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Instruction words are 4-byte aligned; anything else is faulted locally.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters (memory stall cycles, delivered instructions).
// Only compiled into the design when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        handshake,
    output logic [31:0] stall_cycles,
    output logic [31:0] fetch_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            fetch_count  <= 32'd0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack memory read, instruction register, decode handshake, redirects.
// Optional counters enabled with FETCH_PERF_CNT_EN; otherwise stall_cycles/fetch_count read 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    input  logic              redirect,
    output logic              fetch_busy,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_fault,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fetch_count
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W-1:0] tgt_q, tgt_nx;
    logic [ADDR_W-1:0] pc_q, pc_nx;
    logic [DATA_W-1:0] instr_q, instr_nx;
    logic              fault_q, fault_nx;
    logic              valid_q, valid_nx;
    logic              launch;
    logic [ADDR_W-1:0] launch_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            addr_q  <= '0;
            tgt_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            tgt_q   <= tgt_nx;
            pc_q    <= pc_nx;
            instr_q <= instr_nx;
            fault_q <= fault_nx;
            valid_q <= valid_nx;
        end
    end

    // Every path that starts a new fetch goes through 'launch' so the
    // misalignment short-circuit lives in one place.
    always_comb begin
        state_nx    = state;
        addr_nx     = addr_q;
        tgt_nx      = tgt_q;
        pc_nx       = pc_q;
        instr_nx    = instr_q;
        fault_nx    = fault_q;
        valid_nx    = valid_q;
        launch      = 1'b0;
        launch_addr = pc_in;

        case (state)
            BOOT: begin
                launch      = 1'b1;
                launch_addr = redirect ? pc_in : RESET_PC;
            end
            IDLE: begin
                launch = redirect || pc_valid;
            end
            REQ: begin
                if (imem_ack && !redirect) begin
                    instr_nx = imem_rdata;
                    pc_nx    = addr_q;
                    fault_nx = imem_err;
                    valid_nx = 1'b1;
                    state_nx = HOLD;
                end else if (imem_ack) begin
                    launch = 1'b1;
                end else if (redirect) begin
                    tgt_nx   = pc_in;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // The old request must complete before the target can be issued.
                if (imem_ack) begin
                    launch      = 1'b1;
                    launch_addr = redirect ? pc_in : tgt_q;
                end else if (redirect) begin
                    tgt_nx = pc_in;
                end
            end
            HOLD: begin
                if (redirect || (instr_ready && pc_valid)) begin
                    launch = 1'b1;
                end else if (instr_ready) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase

        if (launch) begin
            if (is_misaligned(launch_addr[1:0])) begin
                state_nx = HOLD;
                instr_nx = '0;
                pc_nx    = launch_addr;
                fault_nx = 1'b1;
                valid_nx = 1'b1;
            end else begin
                state_nx = REQ;
                addr_nx  = launch_addr;
                valid_nx = 1'b0;
            end
        end
    end

    assign imem_req    = !reset && (state == REQ || state == DRAIN);
    assign imem_addr   = addr_q;
    assign fetch_busy  = reset || (state == BOOT) || (state == REQ) || (state == DRAIN)
                         || (state == HOLD && !instr_ready);
    assign instr_out   = instr_q;
    assign instr_pc    = pc_q;
    assign instr_fault = fault_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;
    logic hs_evt;

    assign stall_evt = imem_req && !imem_ack;
    assign hs_evt    = valid_q && instr_ready;

    fetch_perf_ctr u_perf (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall_evt),
        .handshake    (hs_evt),
        .stall_cycles (stall_cycles),
        .fetch_count  (fetch_count)
    );
`else
    assign stall_cycles = 32'd0;
    assign fetch_count  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit; random fetches are checked against a
// transaction-level model: a delivered instruction must be the one at the last accepted target.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        redirect;
    logic        fetch_busy;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] stall_cycles;
    logic [31:0] fetch_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned fetch_model = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .redirect     (redirect),
        .fetch_busy   (fetch_busy),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .imem_err     (imem_err),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_fault  (instr_fault),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall_cycles (stall_cycles),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        pc_valid    = 1'b0;
        redirect    = 1'b0;
        imem_ack    = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
    endtask

    task automatic complete(input logic [31:0] data, input logic err);
        imem_ack   = 1'b1;
        imem_rdata = data;
        imem_err   = err;
        tick();
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
    endtask

    task automatic handoff(input logic [31:0] next_pc);
        instr_ready = 1'b1;
        pc_valid    = 1'b1;
        pc_in       = next_pc;
        tick();
        fetch_model++;
        instr_ready = 1'b0;
        pc_valid    = 1'b0;
    endtask

    // Memory contents and error map used by the randomized phase.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[4:2] == 3'd5;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        logic [31:0] target;
        logic [31:0] prev_addr;
        logic        prev_pend;
        logic        done;
        int          nred;

        reset = 1'b1;
        pc_in = 32'h0;
        quiet_inputs();
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_busy", fetch_busy, 1);
        chk("rst_valid", instr_valid, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_fault", instr_fault, 0);
        chk("rst_addr", imem_addr, 0);

        // Boot fetch with a two-cycle memory latency
        reset = 1'b0;
        tick();
        chk("boot_req", imem_req, 1);
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_busy", fetch_busy, 1);
        tick();
        chk("boot_wait_valid", instr_valid, 0);
        complete(32'h2001_0005, 1'b0);
        chk("boot_valid", instr_valid, 1);
        chk("boot_pc", instr_pc, 32'h0);
        chk("boot_out", instr_out, 32'h2001_0005);
        chk("boot_fault", instr_fault, 0);

        // Decode back-pressure while the PC logic keeps offering PC+4
        pc_valid = 1'b1;
        pc_in    = 32'h4;
        for (int i = 0; i < 5; i++) begin
            chk("bp_busy", fetch_busy, 1);
            tick();
            chk("bp_valid", instr_valid, 1);
            chk("bp_out", instr_out, 32'h2001_0005);
            chk("bp_pc", instr_pc, 32'h0);
            chk("bp_noreq", imem_req, 0);
        end
        instr_ready = 1'b1;
        #1;
        chk("bp_busy_release", fetch_busy, 0);
        tick();
        fetch_model++;
        instr_ready = 1'b0;
        pc_valid    = 1'b0;
        chk("bp_next_req", imem_req, 1);
        chk("bp_next_addr", imem_addr, 32'h4);
        chk("bp_next_valid", instr_valid, 0);
        complete(32'h0000_1111, 1'b0);
        chk("seq4_pc", instr_pc, 32'h4);
        chk("seq4_out", instr_out, 32'h0000_1111);
        handoff(32'h8);
        chk("seq8_addr", imem_addr, 32'h8);

        // Redirect while the fetch at 8 is outstanding
        redirect = 1'b1;
        pc_in    = 32'h40;
        tick();
        redirect = 1'b0;
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 32'h8);
        tick();
        tick();
        chk("drain_valid", instr_valid, 0);
        complete(32'hDEAD_BEEF, 1'b0);
        chk("drain_junk_valid", instr_valid, 0);
        chk("drain_new_addr", imem_addr, 32'h40);
        chk("drain_new_req", imem_req, 1);
        complete(32'h4040_4040, 1'b0);
        chk("tgt40_valid", instr_valid, 1);
        chk("tgt40_pc", instr_pc, 32'h40);
        chk("tgt40_out", instr_out, 32'h4040_4040);
        handoff(32'hC);
        chk("seq12_addr", imem_addr, 32'hC);

        // Redirect in the same cycle as the ack
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        redirect   = 1'b1;
        pc_in      = 32'h100;
        tick();
        quiet_inputs();
        chk("same_valid", instr_valid, 0);
        chk("same_addr", imem_addr, 32'h100);
        chk("same_req", imem_req, 1);
        complete(32'h0100_0100, 1'b0);
        chk("tgt100_pc", instr_pc, 32'h100);
        chk("tgt100_out", instr_out, 32'h0100_0100);

        // Bus error, then a misaligned target
        handoff(32'h10);
        complete(32'hE0E0_E0E0, 1'b1);
        chk("err_valid", instr_valid, 1);
        chk("err_fault", instr_fault, 1);
        chk("err_pc", instr_pc, 32'h10);
        handoff(32'h22);
        chk("mis_req", imem_req, 0);
        chk("mis_valid", instr_valid, 1);
        chk("mis_fault", instr_fault, 1);
        chk("mis_pc", instr_pc, 32'h22);
        chk("mis_out", instr_out, 32'h0);
        instr_ready = 1'b1;
        tick();
        fetch_model++;
        instr_ready = 1'b0;
        chk("idle_valid", instr_valid, 0);
        chk("idle_busy", fetch_busy, 0);
        chk("idle_req", imem_req, 0);

        // Reset in the middle of a request, followed by a late ack
        pc_valid = 1'b1;
        pc_in    = 32'h14;
        tick();
        pc_valid = 1'b0;
        chk("mid_addr", imem_addr, 32'h14);
        reset = 1'b1;
        tick();
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_busy", fetch_busy, 1);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        tick();
        quiet_inputs();
        fetch_model = 0;
        chk("late_ack_valid", instr_valid, 0);
        chk("late_ack_addr", imem_addr, 32'h0);
        chk("late_ack_req", imem_req, 1);
        chk("late_stall_cnt", stall_cycles, 0);
        chk("late_fetch_cnt", fetch_count, 0);
        complete(32'hC0DE_0000, 1'b0);
        chk("restart_pc", instr_pc, 32'h0);
        chk("restart_out", instr_out, 32'hC0DE_0000);
        instr_ready = 1'b1;
        tick();
        fetch_model++;
        instr_ready = 1'b0;

        // Randomized fetches with random latency and in-flight redirects
        for (int t = 0; t < 60; t++) begin
            target = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                chk("rnd_idle_busy", fetch_busy, 0);
                pc_valid = 1'b1;
            end else begin
                redirect = 1'b1;
            end
            pc_in = target;
            tick();
            pc_valid  = 1'b0;
            redirect  = 1'b0;
            nred      = 0;
            done      = 1'b0;
            prev_pend = 1'b0;
            prev_addr = 32'h0;
            for (int c = 0; c < 200 && !done; c++) begin
                if (instr_valid) begin
                    done = 1'b1;
                end else begin
                    if (prev_pend) begin
                        chk("rnd_req_held", imem_req, 1);
                        chk("rnd_addr_stable", imem_addr, prev_addr);
                    end
                    if (imem_req && $urandom_range(0, 2) == 0) begin
                        chk("rnd_aligned", imem_addr & 32'h3, 32'h0);
                        imem_ack   = 1'b1;
                        imem_rdata = mem_data(imem_addr);
                        imem_err   = mem_err(imem_addr);
                    end
                    if (nred < 2 && $urandom_range(0, 5) == 0) begin
                        target   = rand_addr();
                        redirect = 1'b1;
                        pc_in    = target;
                        nred++;
                    end
                    prev_pend = imem_req && !imem_ack;
                    prev_addr = imem_addr;
                    tick();
                    imem_ack = 1'b0;
                    imem_err = 1'b0;
                    redirect = 1'b0;
                end
            end
            chk("rnd_delivered", done, 1);
            if (!done) break;
            chk("rnd_pc", instr_pc, target);
            chk("rnd_fault", instr_fault, (target[1:0] != 2'b00) || mem_err(target));
            chk("rnd_out", instr_out, (target[1:0] != 2'b00) ? 32'h0 : mem_data(target));
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("rnd_hold_valid", instr_valid, 1);
                chk("rnd_hold_pc", instr_pc, target);
            end
            instr_ready = 1'b1;
            tick();
            fetch_model++;
            instr_ready = 1'b0;
            chk("rnd_retired", instr_valid, 0);
        end

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_count", fetch_count, fetch_model);
`else
        chk("perf_fetch_tied", fetch_count, 0);
        chk("perf_stall_tied", stall_cycles, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC next-address logic.
- Takes the next-PC value, issues a req/ack read to instruction memory and holds the returned word in an instruction register.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Handles variable memory latency, decode back-pressure and redirects (taken branch/jump/reg-to-PC) that arrive while a fetch is outstanding.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pc_in  in  ADDR_W  next-PC / redirect target from PC logic
- pc_valid  in  1  sequential next-PC offered this cycle
- redirect  in  1  pc_in is a control-flow target; discard any fetched or in-flight instruction
- fetch_busy  out  1  pc_valid cannot be accepted this cycle (PC register write-enable = ~fetch_busy)
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_W  request address
- imem_ack  in  1  read data valid, completes the request
- imem_rdata  in  DATA_W  read data
- imem_err  in  1  bus error, qualified by imem_ack
- instr_out  out  DATA_W  held instruction word
- instr_pc  out  ADDR_W  address of instr_out
- instr_fault  out  1  instr_out came from an errored or misaligned fetch
- instr_valid  out  1  instr_out/instr_pc/instr_fault valid
- instr_ready  in  1  decode accepts this cycle

Behaviour:
- Reset (synchronous, priority over all inputs):
  - State goes to BOOT.
  - imem_req=0, imem_addr=0, instr_out=0, instr_pc=0, instr_fault=0, instr_valid=0, fetch_busy=1.
  - Reset mid-transaction abandons it. A late imem_ack after reset is ignored while in BOOT/IDLE.
- States: BOOT, IDLE, REQ, HOLD, DRAIN.
- BOOT: one cycle. Loads imem_addr=RESET_PC and goes to REQ.
- IDLE: imem_req=0, fetch_busy=0.
  - redirect or pc_valid: imem_addr<=pc_in, go to REQ.
  - redirect has priority.
- REQ: imem_req=1. imem_addr is stable until imem_ack; a request is never withdrawn.
  - ack, no redirect: instr_out<=imem_rdata, instr_pc<=imem_addr, instr_fault<=imem_err, instr_valid<=1, go to HOLD. Fetch latency is 1 cycle after ack.
  - ack with redirect same cycle: discard data, imem_addr<=pc_in, stay in REQ with a new request.
  - redirect without ack: tgt<=pc_in, go to DRAIN.
- DRAIN: imem_req=1 (old address) until ack.
  - On ack: discard data, imem_addr<=tgt, go to REQ.
  - A further redirect in DRAIN overwrites tgt (last target wins).
- HOLD: instr_valid=1; outputs stable until handshake.
  - redirect: instr_valid<=0, imem_addr<=pc_in, go to REQ. Redirect wins over instr_ready.
  - instr_ready && pc_valid: handshake, instr_valid<=0, imem_addr<=pc_in, go to REQ.
  - instr_ready only: instr_valid<=0, go to IDLE.
- fetch_busy = 1 in BOOT/REQ/DRAIN, and in HOLD when instr_ready=0. Otherwise 0.
- Misalignment: pc_in[1:0]!=0 is not sent to memory. The unit goes directly to HOLD with instr_out=0, instr_pc=pc_in, instr_fault=1.
- redirect is always accepted regardless of fetch_busy. pc_valid is ignored while fetch_busy=1.
- No address arithmetic is done here; PC+4/branch adders stay in the PC logic.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_cycles and fetch_count.
  - stall_cycles increments each cycle in REQ/DRAIN without imem_ack.
  - fetch_count increments on each instr_valid&&instr_ready handshake.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports exist but are tied to 0, so the interface is unchanged; no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - state encoding constants (BOOT=0, IDLE=1, REQ=2, HOLD=3, DRAIN=4, 3 bits)
  - ADDR_W/DATA_W defaults and RESET_PC default
- Optional sub-module fetch_perf_ctr: the two counters, instantiated only under FETCH_PERF_CNT_EN.
- Everything else stays inline.

Test Plan:
- Boot: release reset, memory acks 2 cycles later with 32'h2001_0005 → imem_addr=0; instr_valid=1, instr_pc=0, instr_out=32'h2001_0005 the cycle after ack.
- Back-pressure: HOLD with instr_ready=0 for 5 cycles while pc_valid=1, pc_in=4 → outputs stable, fetch_busy=1, no new imem_req; instr_ready=1 → next imem_addr=4.
- Redirect in flight: REQ addr 8, no ack, redirect pc_in=32'h40; ack 3 cycles later with junk → junk never appears on instr_valid; next request addr=32'h40.
- Redirect with same-cycle ack at addr 12, target 32'h100 → data discarded; REQ addr 32'h100 next cycle; instr_valid stays 0.
- Error/misalign: imem_err=1 on ack at addr 16 → instr_fault=1, instr_pc=16. pc_in=32'h22 → no imem_req, instr_fault=1, instr_pc=32'h22.
- Reset mid-REQ (addr 20), then late ack → ignored; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, counters read 0.
